// File: rtl/mem_dump_reader.sv
// Streams an inclusive, optionally wrapping, address range out of a synchronous RAM.
// Each byte takes a fixed ISSUE/WAIT/CAPTURE access, then a valid/ready beat in SEND.
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_capture;
  logic                  w_access;

  // Abort beats everything in non-IDLE states, including a same-cycle handshake.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE:   w_next = abort ? S_IDLE : S_WAIT;
      S_WAIT:    w_next = abort ? S_IDLE : S_CAPTURE;
      S_CAPTURE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (out_ready) begin
          if (r_cur == r_last) begin
            w_next = S_DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_ISSUE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The RAM address register only moves on entry to ISSUE, so it is stable
  // for the whole access and simply holds between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_last     <= '0;
      r_mem_addr <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cur      <= start_addr;
        r_last     <= end_addr;
        r_mem_addr <= start_addr;
      end
      if (w_advance) begin
        r_cur      <= r_cur + ADDR_ONE;
        r_mem_addr <= r_cur + ADDR_ONE;
      end
      if (w_capture) begin
        r_out_data <= mem_data;
        r_out_addr <= r_cur;
      end
    end
  end

  assign w_access  = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign mem_addr  = r_mem_addr;
  assign mem_cs    = w_access;
  assign mem_oe    = w_access;
  assign mem_we    = 1'b0;
  assign out_valid = (r_state == S_SEND);
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
